// File: rtl/serial_word_tx_pkg.sv
// Shared types and helpers for the bit-serial word transmitter.
// Holds the transmitter state enum, the remainder type and the mod-5 step function
// used by the optional remainder tracker (built when MOD5_TRACK_EN is defined).
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    typedef logic [2:0] rem_t;

    // Appending one bit to a number whose value mod 5 is rem gives (2*rem + bit) mod 5.
    // With rem in 0..4 the intermediate value is at most 9, so one subtraction suffices.
    function automatic rem_t mod5_step(input rem_t rem, input logic bit_in);
        logic [3:0] acc;
        acc = {rem, 1'b0} + {3'b000, bit_in};
        if (acc >= 4'd5) begin
            acc = acc - 4'd5;
        end
        return acc[2:0];
    endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Handshake bundle of the serial word transmitter: parallel word input port and
// the framed serial output port. The slave modport is the transmitter's view,
// the master modport is the view of whatever feeds words and consumes bits.
interface serial_word_tx_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_bit;
    logic             ser_first;
    logic             ser_last;

    modport master (
        output in_valid,
        output in_data,
        output ser_ready,
        input  in_ready,
        input  ser_valid,
        input  ser_bit,
        input  ser_first,
        input  ser_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  ser_ready,
        output in_ready,
        output ser_valid,
        output ser_bit,
        output ser_first,
        output ser_last
    );

endinterface

// File: rtl/serial_word_tx_tracker.sv
// Running mod-5 remainder of the bit stream leaving the transmitter.
// Only built when MOD5_TRACK_EN is defined. The result of a word is captured on its
// last beat and presented for one cycle, so a new word may clear the running value
// on that same beat without disturbing the reported result.
`ifdef MOD5_TRACK_EN
module mod5_tracker
    import serial_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    input  logic step_bit,
    input  logic last,
    output rem_t rem,
    output logic done
);

    rem_t run_q;
    rem_t result_q;
    logic done_q;

    // Fold each transmitted bit into the running remainder and latch the final value per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= step & last;
            if (step && last) begin
                result_q <= mod5_step(run_q, step_bit);
            end
            if (clear || (step && last)) begin
                run_q <= '0;
            end else if (step) begin
                run_q <= mod5_step(run_q, step_bit);
            end
        end
    end

    assign rem  = result_q;
    assign done = done_q;

endmodule
`endif

// File: rtl/serial_word_tx.sv
// Serialises parallel words MSB-first with first/last framing on a valid/ready stream.
// GAP forces idle cycles after each word; with GAP==0 the next word loads on the
// last-bit beat so consecutive words stream without a bubble.
// Optional feature macro MOD5_TRACK_EN: builds the mod-5 tracker that reports each
// word's remainder one cycle after its last bit; otherwise exp_* are tied low.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_tx_if.slave        bus,
    output logic                   busy,
    output logic                   exp_valid,
    output logic                   exp_div5,
    output logic [2:0]             exp_rem
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;

    logic in_shift;
    logic at_last;
    logic beat;
    logic last_beat;
    logic accept;
    logic gap_done;

    assign in_shift  = (state_q == SHIFT);
    assign at_last   = in_shift && (cnt_q == CW'(WIDTH - 1));
    assign beat      = in_shift && bus.ser_ready;
    assign last_beat = beat && at_last;
    assign accept    = bus.in_valid && bus.in_ready;
    assign gap_done  = (gap_q == GW'(GAP - 1));

    // State register; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load on accept, leave SHIFT on the last-bit beat, count out the gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_beat) begin
                    if (GAP == 0) begin
                        state_d = accept ? SHIFT : IDLE;
                    end else begin
                        state_d = serial_tx_pkg::GAP;
                    end
                end
            end
            serial_tx_pkg::GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; the serial side only moves on a beat so it holds while stalled.
    always_comb begin
        bus.ser_valid = in_shift;
        bus.ser_bit   = in_shift & shift_q[WIDTH-1];
        bus.ser_first = in_shift && (cnt_q == '0);
        bus.ser_last  = at_last;
        bus.in_ready  = (state_q == IDLE) || ((GAP == 0) && last_beat);
        busy          = (state_q != IDLE);
    end

    // Shift register and bit counter: load on accept, advance on each beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shift_q <= bus.in_data;
            cnt_q   <= '0;
        end else if (beat) begin
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            if (!at_last) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Gap cycle counter, only running while in the gap state.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else if (state_q == serial_tx_pkg::GAP) begin
            gap_q <= gap_q + 1'b1;
        end else begin
            gap_q <= '0;
        end
    end

`ifdef MOD5_TRACK_EN
    rem_t trk_rem;
    logic trk_done;

    mod5_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .step     (beat),
        .step_bit (bus.ser_bit),
        .last     (at_last),
        .rem      (trk_rem),
        .done     (trk_done)
    );

    assign exp_valid = trk_done;
    assign exp_rem   = trk_rem;
    assign exp_div5  = trk_done && (trk_rem == 3'd0);
`else
    assign exp_valid = 1'b0;
    assign exp_rem   = 3'd0;
    assign exp_div5  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a GAP=0 instance checked by a scoreboard
// fed from an arithmetic reference, plus a GAP=2 instance for the forced idle gap.
// Exp_* checks follow MOD5_TRACK_EN the same way the design does.
module tb_serial_word_tx;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } bit_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_word_tx_if #(.WIDTH(W)) bus0 ();
    serial_word_tx_if #(.WIDTH(W)) bus2 ();

    logic       busy0, exp_valid0, exp_div50;
    logic [2:0] exp_rem0;
    logic       busy2, exp_valid2, exp_div52;
    logic [2:0] exp_rem2;

    serial_word_tx #(.WIDTH(W), .GAP(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0.slave),
        .busy      (busy0),
        .exp_valid (exp_valid0),
        .exp_div5  (exp_div50),
        .exp_rem   (exp_rem0)
    );

    serial_word_tx #(.WIDTH(W), .GAP(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2.slave),
        .busy      (busy2),
        .exp_valid (exp_valid2),
        .exp_div5  (exp_div52),
        .exp_rem   (exp_rem2)
    );

    int checks   = 0;
    int failures = 0;

    bit_exp_t bit_q[$];
    int       res_q[$];

    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;

    int   run_len  = 0;
    int   last_run = 0;
    logic exp_due  = 1'b0;
    logic prev_hold = 1'b0;
    logic [3:0] prev_snap = '0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a word leaves MSB first, framed on its top and bottom bit, remainder = word % 5.
    function automatic void push_expected(input int w);
        bit_exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b = 1'((w >> i) & 1);
            e.f = (i == W - 1);
            e.l = (i == 0);
            bit_q.push_back(e);
        end
`ifdef MOD5_TRACK_EN
        res_q.push_back(w % 5);
`endif
    endfunction

    // Downstream readiness for dut0: scripted or random, applied away from the clock edge.
    always @(posedge clk) begin
        #2;
        bus0.ser_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: pops the scoreboard on every beat and checks holds and result pulses.
    always @(negedge clk) begin
        bit_exp_t e;
        int r;
        if (rst) begin
            bit_q.delete();
            res_q.delete();
            exp_due   = 1'b0;
            prev_hold = 1'b0;
            run_len   = 0;
        end else begin
`ifdef MOD5_TRACK_EN
            if (exp_due) begin
                checkOutput("exp_valid", int'(exp_valid0), 1);
                if (res_q.size() == 0) begin
                    checkOutput("exp_queue_nonempty", 0, 1);
                end else begin
                    r = res_q.pop_front();
                    checkOutput("exp_rem", int'(exp_rem0), r);
                    checkOutput("exp_div5", int'(exp_div50), int'(r == 0));
                end
            end else begin
                checkOutput("exp_valid_idle", int'(exp_valid0), 0);
            end
`else
            checkOutput("exp_tied_low", int'({exp_valid0, exp_div50, exp_rem0}), 0);
`endif
            if (prev_hold) begin
                checkOutput("stall_hold", int'({bus0.ser_valid, bus0.ser_bit, bus0.ser_first, bus0.ser_last}),
                            int'(prev_snap));
            end
            exp_due = 1'b0;
            if (bus0.ser_valid && bus0.ser_ready) begin
                if (bit_q.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    e = bit_q.pop_front();
                    checkOutput("ser_bit", int'(bus0.ser_bit), int'(e.b));
                    checkOutput("ser_first", int'(bus0.ser_first), int'(e.f));
                    checkOutput("ser_last", int'(bus0.ser_last), int'(e.l));
                end
                exp_due = bus0.ser_last;
            end
            prev_hold = bus0.ser_valid && !bus0.ser_ready;
            prev_snap = {bus0.ser_valid, bus0.ser_bit, bus0.ser_first, bus0.ser_last};
            if (bus0.ser_valid) begin
                run_len++;
            end else if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    // Offer one word to dut0 and hold it until accepted; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] w);
        int waited;
        bit accepted;
        waited   = 0;
        accepted = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = w;
        while (!accepted && waited < 300) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                push_expected(int'(w));
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        bus0.in_valid = 1'b0;
        if (!accepted) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            checkOutput("first_latency", int'({bus0.ser_valid, bus0.ser_first}), 3);
        end
    endtask

    // Wait for dut0 to go idle and for the trailing result pulse to be checked.
    task automatic wait_idle();
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (busy0 && waited < 500);
        if (busy0) begin
            checkOutput("idle_timeout", 0, 1);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        rst            = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of both instances.
        checkOutput("rst_ser_valid", int'(bus0.ser_valid), 0);
        checkOutput("rst_ser_frame", int'({bus0.ser_bit, bus0.ser_first, bus0.ser_last}), 0);
        checkOutput("rst_busy", int'(busy0), 0);
        checkOutput("rst_in_ready", int'(bus0.in_ready), 1);
        checkOutput("rst_exp", int'({exp_valid0, exp_div50, exp_rem0}), 0);
        checkOutput("rst_in_ready_gap", int'(bus2.in_ready), 1);

        // Directed words with downstream always ready.
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'd35);
        wait_idle();
        applyStimulus(8'd36);
        wait_idle();
        applyStimulus(8'd0);
        wait_idle();
        applyStimulus(8'd255);
        wait_idle();

        // Two words held back to back must stream without a bubble.
        applyStimulus(8'd10);
        applyStimulus(8'd11);
        wait_idle();
        checkOutput("b2b_run_len", last_run, 16);

        // Three-cycle stall while the fourth bit of 0xA5 is presented.
        applyStimulus(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_idle();
        checkOutput("stall_run_len", last_run, 11);

        // Reset while the fifth bit of 0x5A is on the wire aborts the word.
        applyStimulus(8'h5A);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_ser_valid", int'(bus0.ser_valid), 0);
        checkOutput("abort_busy", int'(busy0), 0);
        checkOutput("abort_in_ready", int'(bus0.in_ready), 1);
        rst = 1'b0;
        applyStimulus(8'h3C);
        wait_idle();

        // Random words, random spacing and random downstream stalls.
        rand_ready = 1'b1;
        repeat (40) begin
            applyStimulus(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        wait_idle();
        checkOutput("scoreboard_drained", bit_q.size() + res_q.size(), 0);

        // Forced two-cycle gap on the GAP=2 instance; a waiting word must be ignored through it.
        bus2.in_valid = 1'b1;
        bus2.in_data  = 8'h33;
        @(posedge clk);
        #1;
        bus2.in_data = 8'hC4;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(bus2.ser_valid && bus2.ser_last) && waited < 50);
        checkOutput("gap_last_seen", int'(bus2.ser_valid && bus2.ser_last), 1);
        checkOutput("gap_ready_on_last", int'(bus2.in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("gap_in_ready", int'(bus2.in_ready), 0);
            checkOutput("gap_ser_valid", int'(bus2.ser_valid), 0);
            checkOutput("gap_busy", int'(busy2), 1);
        end
        @(negedge clk);
        checkOutput("gap_ready_after", int'(bus2.in_ready), 1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        checkOutput("gap_next_first", int'({bus2.ser_valid, bus2.ser_first, bus2.ser_bit}), 7);
        waited = 0;
        while (busy2 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("gap_idle", int'(busy2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
